aemb_fsl_resp: RTL and testbench

AEMB_FSL_RESP -- requirements
Module: aemb_fsl_resp

---
 rtl/aemb_fsl_resp_if.sv | 31 +++
 rtl/aemb_fsl_resp.sv | 143 ++++++++++++++
 tb/tb_aemb_fsl_resp.sv | 279 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/aemb_fsl_resp_if.sv
// FSL request/acknowledge bus between a core (master)
// and an FSL responder (slave).
interface aemb_fsl_resp_if;
  logic        fsl_stb_i;
  logic        fsl_wre_i;
  logic [4:0]  fsl_adr_i;
  logic [1:0]  fsl_tag_i;
  logic [31:0] fsl_dat_i;
  logic [31:0] fsl_dat_o;
  logic        fsl_ack_o;

  modport master (
    output fsl_stb_i,
    output fsl_wre_i,
    output fsl_adr_i,
    output fsl_tag_i,
    output fsl_dat_i,
    input  fsl_dat_o,
    input  fsl_ack_o
  );

  modport slave (
    input  fsl_stb_i,
    input  fsl_wre_i,
    input  fsl_adr_i,
    input  fsl_tag_i,
    input  fsl_dat_i,
    output fsl_dat_o,
    output fsl_ack_o
  );
endinterface

// File: rtl/aemb_fsl_resp.sv
// FSL channel responder: blocking put into a TX FIFO,
// blocking get from an RX FIFO, one-cycle registered ack.
module aemb_fsl_resp #(
  parameter logic [4:0] CHAN = 5'd0,
  parameter int         AW   = 2
) (
  input  logic                sys_clk_i,
  input  logic                sys_rst_i,
  aemb_fsl_resp_if.slave      fsl,
  output logic [31:0]         tx_dat_o,
  output logic [1:0]          tx_tag_o,
  output logic                tx_vld_o,
  input  logic                tx_rdy_i,
  input  logic [31:0]         rx_dat_i,
  input  logic                rx_vld_i,
  output logic                rx_rdy_o,
  output logic [AW:0]         tx_lvl_o,
  output logic [AW:0]         rx_lvl_o
);

  localparam int          DEPTH = 1 << AW;
  localparam logic [AW:0] FULL  = (AW+1)'(DEPTH);

  logic [33:0]   r_tx_mem [DEPTH];
  logic [AW-1:0] r_tx_wp;
  logic [AW-1:0] r_tx_rp;
  logic [AW:0]   r_tx_lvl;

  logic [31:0]   r_rx_mem [DEPTH];
  logic [AW-1:0] r_rx_wp;
  logic [AW-1:0] r_rx_rp;
  logic [AW:0]   r_rx_lvl;

  logic          r_ack;
  logic [31:0]   r_dat;

  logic w_elig;
  logic w_hit;
  logic w_miss;
  logic w_tx_full;
  logic w_tx_pop;
  logic w_tx_push;
  logic w_rx_full;
  logic w_rx_push;
  logic w_rx_pop;
  logic w_svc;

  // A request is only considered while no ack is
  // outstanding, so stb held across the ack is ignored.
  assign w_elig = fsl.fsl_stb_i & ~r_ack;
  assign w_hit  = (fsl.fsl_adr_i == CHAN);
  assign w_miss = w_elig & ~w_hit;

  assign w_tx_full = (r_tx_lvl == FULL);
  assign w_tx_pop  = (r_tx_lvl != '0) & tx_rdy_i;
  // A full TX still accepts a put when the head leaves
  // in the same cycle.
  assign w_tx_push = w_elig & w_hit & fsl.fsl_wre_i
                   & (~w_tx_full | w_tx_pop);

  assign w_rx_full = (r_rx_lvl == FULL);
  assign w_rx_push = rx_vld_i & ~w_rx_full;
  assign w_rx_pop  = w_elig & w_hit & ~fsl.fsl_wre_i
                   & (r_rx_lvl != '0);

  assign w_svc = w_tx_push | w_rx_pop | w_miss;

  assign fsl.fsl_ack_o = r_ack;
  assign fsl.fsl_dat_o = r_dat;

  assign tx_dat_o = r_tx_mem[r_tx_rp][31:0];
  assign tx_tag_o = r_tx_mem[r_tx_rp][33:32];
  assign tx_vld_o = (r_tx_lvl != '0);
  assign tx_lvl_o = r_tx_lvl;

  assign rx_rdy_o = ~w_rx_full;
  assign rx_lvl_o = r_rx_lvl;

  // Ack pulse and get-data register.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_ack <= 1'b0;
      r_dat <= '0;
    end else begin
      r_ack <= w_svc;
      if (w_rx_pop)
        r_dat <= r_rx_mem[r_rx_rp];
      else if (w_miss & ~fsl.fsl_wre_i)
        r_dat <= '0;
    end
  end

  // TX storage; contents are meaningful only via pointers.
  always_ff @(posedge sys_clk_i) begin
    if (w_tx_push)
      r_tx_mem[r_tx_wp] <= {fsl.fsl_tag_i, fsl.fsl_dat_i};
  end

  // TX pointers and occupancy.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_tx_wp  <= '0;
      r_tx_rp  <= '0;
      r_tx_lvl <= '0;
    end else begin
      if (w_tx_push)
        r_tx_wp <= r_tx_wp + 1'b1;
      if (w_tx_pop)
        r_tx_rp <= r_tx_rp + 1'b1;
      unique case ({w_tx_push, w_tx_pop})
        2'b10:   r_tx_lvl <= r_tx_lvl + 1'b1;
        2'b01:   r_tx_lvl <= r_tx_lvl - 1'b1;
        default: r_tx_lvl <= r_tx_lvl;
      endcase
    end
  end

  // RX storage.
  always_ff @(posedge sys_clk_i) begin
    if (w_rx_push)
      r_rx_mem[r_rx_wp] <= rx_dat_i;
  end

  // RX pointers and occupancy.
  always_ff @(posedge sys_clk_i) begin
    if (sys_rst_i) begin
      r_rx_wp  <= '0;
      r_rx_rp  <= '0;
      r_rx_lvl <= '0;
    end else begin
      if (w_rx_push)
        r_rx_wp <= r_rx_wp + 1'b1;
      if (w_rx_pop)
        r_rx_rp <= r_rx_rp + 1'b1;
      unique case ({w_rx_push, w_rx_pop})
        2'b10:   r_rx_lvl <= r_rx_lvl + 1'b1;
        2'b01:   r_rx_lvl <= r_rx_lvl - 1'b1;
        default: r_rx_lvl <= r_rx_lvl;
      endcase
    end
  end

endmodule

// File: tb/tb_aemb_fsl_resp.sv
// Bench for aemb_fsl_resp: directed scenarios plus random
// traffic against a queue-based reference model.
module tb_aemb_fsl_resp;

  localparam logic [4:0] CHAN  = 5'd5;
  localparam logic [4:0] OTHER = 5'd6;
  localparam int         AW    = 2;
  localparam int         DEPTH = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic [31:0]   tx_dat;
  logic [1:0]    tx_tag;
  logic          tx_vld;
  logic          tx_rdy;
  logic [31:0]   rx_dat;
  logic          rx_vld;
  logic          rx_rdy;
  logic [AW:0]   tx_lvl;
  logic [AW:0]   rx_lvl;

  always #5 clk = ~clk;

  aemb_fsl_resp_if fsl ();

  aemb_fsl_resp #(.CHAN(CHAN), .AW(AW)) dut (
    .sys_clk_i (clk),
    .sys_rst_i (rst),
    .fsl       (fsl.slave),
    .tx_dat_o  (tx_dat),
    .tx_tag_o  (tx_tag),
    .tx_vld_o  (tx_vld),
    .tx_rdy_i  (tx_rdy),
    .rx_dat_i  (rx_dat),
    .rx_vld_i  (rx_vld),
    .rx_rdy_o  (rx_rdy),
    .tx_lvl_o  (tx_lvl),
    .rx_lvl_o  (rx_lvl)
  );

  bit [33:0] tx_q [$];
  bit [31:0] rx_q [$];
  bit        m_ack;
  bit [31:0] m_dat;
  int        nchk;
  int        nerr;

  task automatic chk(string tag, logic [63:0] obs,
                     logic [63:0] exp);
    nchk++;
    assert (obs === exp) else begin
      nerr++;
      $error("FAIL %s observed=%0h expected=%0h",
             tag, obs, exp);
    end
  endtask

  // One clock: predict from the current inputs, let the
  // edge happen, then compare every DUT output.
  task automatic step();
    bit        elig, txpop, rxpush, svc, pushtx, poprx;
    bit [31:0] nd;
    bit [33:0] pe;
    bit [31:0] rd;
    elig   = fsl.fsl_stb_i && !m_ack;
    txpop  = tx_q.size() > 0 && tx_rdy;
    rxpush = rx_vld && rx_q.size() < DEPTH;
    svc    = 0;
    pushtx = 0;
    poprx  = 0;
    nd     = m_dat;
    pe     = {fsl.fsl_tag_i, fsl.fsl_dat_i};
    rd     = rx_dat;
    if (elig) begin
      if (fsl.fsl_adr_i != CHAN) begin
        svc = 1;
        if (!fsl.fsl_wre_i) nd = 0;
      end else if (fsl.fsl_wre_i) begin
        if (tx_q.size() < DEPTH || txpop) begin
          svc = 1;
          pushtx = 1;
        end
      end else if (rx_q.size() > 0) begin
        svc = 1;
        poprx = 1;
        nd = rx_q[0];
      end
    end
    @(posedge clk);
    #1;
    if (rst) begin
      tx_q.delete();
      rx_q.delete();
      m_ack = 0;
      m_dat = 0;
    end else begin
      if (txpop)  void'(tx_q.pop_front());
      if (pushtx) tx_q.push_back(pe);
      if (poprx)  void'(rx_q.pop_front());
      if (rxpush) rx_q.push_back(rd);
      m_ack = svc;
      m_dat = nd;
    end
    chk("ack", fsl.fsl_ack_o, m_ack);
    chk("dat", fsl.fsl_dat_o, m_dat);
    chk("tx_vld", tx_vld, tx_q.size() != 0);
    chk("tx_lvl", tx_lvl, tx_q.size());
    chk("rx_rdy", rx_rdy, rx_q.size() < DEPTH);
    chk("rx_lvl", rx_lvl, rx_q.size());
    if (tx_q.size() != 0)
      chk("tx_head", {tx_tag, tx_dat}, tx_q[0]);
  endtask

  // Blocking request: hold stb until the ack, bounded.
  task automatic req(bit wre, bit [4:0] adr, bit [1:0] tag,
                     bit [31:0] dat, int maxc);
    int n;
    n = 0;
    fsl.fsl_stb_i = 1;
    fsl.fsl_wre_i = wre;
    fsl.fsl_adr_i = adr;
    fsl.fsl_tag_i = tag;
    fsl.fsl_dat_i = dat;
    do begin
      step();
      n++;
    end while (!m_ack && n < maxc);
    chk("req_ack", fsl.fsl_ack_o, 1);
    fsl.fsl_stb_i = 0;
  endtask

  initial begin
    bit [31:0] d [5];
    bit [31:0] v;
    bit        pend;
    nchk = 0;
    nerr = 0;
    rst = 1;
    fsl.fsl_stb_i = 0;
    fsl.fsl_wre_i = 0;
    fsl.fsl_adr_i = 0;
    fsl.fsl_tag_i = 0;
    fsl.fsl_dat_i = 0;
    tx_rdy = 0;
    rx_vld = 0;
    rx_dat = 0;

    // Reset state
    step();
    step();
    chk("rst_ack", fsl.fsl_ack_o, 0);
    chk("rst_dat", fsl.fsl_dat_o, 0);
    chk("rst_txvld", tx_vld, 0);
    chk("rst_rxrdy", rx_rdy, 1);
    rst = 0;
    step();

    // Single put, visible at TX head
    req(1, CHAN, 2'd2, 32'h12345678, 4);
    chk("put_txdat", tx_dat, 32'h12345678);
    chk("put_txtag", tx_tag, 2);
    chk("put_txlvl", tx_lvl, 1);
    step();
    chk("put_txvld", tx_vld, 1);
    tx_rdy = 1;
    step();
    tx_rdy = 0;
    chk("drain_txvld", tx_vld, 0);

    // Get blocks on empty RX, completes after a push
    fsl.fsl_stb_i = 1;
    fsl.fsl_wre_i = 0;
    fsl.fsl_adr_i = CHAN;
    repeat (5) begin
      step();
      chk("get_stall", fsl.fsl_ack_o, 0);
    end
    rx_vld = 1;
    rx_dat = 32'hCAFEF00D;
    step();
    chk("get_nopush_ack", fsl.fsl_ack_o, 0);
    rx_vld = 0;
    step();
    chk("get_ack", fsl.fsl_ack_o, 1);
    chk("get_dat", fsl.fsl_dat_o, 32'hCAFEF00D);
    fsl.fsl_stb_i = 0;
    step();
    chk("get_rxlvl", rx_lvl, 0);
    chk("get_dat_hold", fsl.fsl_dat_o, 32'hCAFEF00D);

    // Fill TX, fifth put stalls, then pop+push when full
    for (int i = 0; i < 5; i++) d[i] = $urandom;
    for (int i = 0; i < 4; i++)
      req(1, CHAN, 2'(i), d[i], 4);
    fsl.fsl_stb_i = 1;
    fsl.fsl_wre_i = 1;
    fsl.fsl_adr_i = CHAN;
    fsl.fsl_tag_i = 2'd3;
    fsl.fsl_dat_i = d[4];
    repeat (3) begin
      step();
      chk("full_stall", fsl.fsl_ack_o, 0);
      chk("full_lvl", tx_lvl, 4);
    end
    tx_rdy = 1;
    step();
    tx_rdy = 0;
    fsl.fsl_stb_i = 0;
    chk("full_ack", fsl.fsl_ack_o, 1);
    chk("full_lvl_same", tx_lvl, 4);
    tx_rdy = 1;
    for (int i = 1; i < 5; i++) begin
      chk("order", tx_dat, d[i]);
      step();
    end
    tx_rdy = 0;
    chk("order_empty", tx_vld, 0);

    // Other-channel requests
    v = $urandom;
    rx_vld = 1;
    rx_dat = v;
    step();
    rx_vld = 0;
    req(0, OTHER, 0, 0, 4);
    chk("miss_get_dat", fsl.fsl_dat_o, 0);
    chk("miss_rxlvl", rx_lvl, 1);
    req(1, OTHER, 1, $urandom, 4);
    chk("miss_txlvl", tx_lvl, 0);
    req(0, CHAN, 0, 0, 4);
    chk("hit_get_dat", fsl.fsl_dat_o, v);

    // Reset with a pending put and TX level 3
    for (int i = 0; i < 3; i++)
      req(1, CHAN, 2'(i), $urandom, 4);
    fsl.fsl_stb_i = 1;
    fsl.fsl_wre_i = 1;
    fsl.fsl_adr_i = CHAN;
    rst = 1;
    step();
    rst = 0;
    fsl.fsl_stb_i = 0;
    step();
    chk("rst2_ack", fsl.fsl_ack_o, 0);
    chk("rst2_txlvl", tx_lvl, 0);
    chk("rst2_txvld", tx_vld, 0);
    chk("rst2_rxrdy", rx_rdy, 1);

    // Random traffic
    pend = 0;
    for (int c = 0; c < 600; c++) begin
      tx_rdy = ($urandom % 3) == 0;
      rx_vld = ($urandom % 3) != 0;
      rx_dat = $urandom;
      if (!pend && ($urandom % 2) == 0) begin
        pend = 1;
        fsl.fsl_stb_i = 1;
        fsl.fsl_wre_i = $urandom;
        fsl.fsl_adr_i = (($urandom % 5) == 0) ?
                        5'($urandom) : CHAN;
        fsl.fsl_tag_i = $urandom;
        fsl.fsl_dat_i = $urandom;
      end
      step();
      if (pend && (m_ack || ($urandom % 16) == 0)) begin
        pend = 0;
        fsl.fsl_stb_i = 0;
      end
    end
    tx_rdy = 0;
    rx_vld = 0;
    fsl.fsl_stb_i = 0;
    step();

    $display("Result: errors=%0d of %0d checks", nerr, nchk);
    $finish;
  end

endmodule
